obi_mem_responder: RTL

OBI slave endpoint that serves one word-addressed SRAM bank behind the system crossbar's RAM slave ports (`ram_req_o[k]` / `ram_resp_i[k]`). It grants requests under an outstanding-transaction limit. Reads and writes are performed at grant time. Each granted transaction gets exactly one in-order `rvalid` after a fixed, parameterised latency. Out-of-range accesses are flagged and counted, which makes the block also usable as a behavioural bank for crossbar verification.

---
 rtl/obi_mem_responder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/obi_mem_responder.sv
// OBI slave endpoint backed by one word-addressed SRAM bank.
// Requests are granted under an outstanding limit. Each grant produces
// exactly one in-order response after a fixed pipeline latency.
// Out-of-range accesses are flagged and counted.

package obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module obi_mem_responder
  import obi_pkg::*;
#(
  parameter int unsigned NUM_WORDS       = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  obi_req_t    slave_req_i,
  output obi_resp_t   slave_resp_o,
  input  logic        stall_i,
  output logic        oob_o,
  output logic [15:0] oob_count_o,
  output logic [2:0]  outstanding_o
);

  localparam int unsigned AW          = $clog2(NUM_WORDS);
  localparam logic [31:0] RANGE_BYTES = 32'(NUM_WORDS * 4);
  localparam logic [31:0] OOB_RDATA   = 32'hBADA_CCE5;
  localparam logic [2:0]  MAX_OUT     = 3'(MAX_OUTSTANDING);

  logic [31:0] mem_q [NUM_WORDS];

  logic [LATENCY-1:0]       valid_q, valid_d;
  logic [LATENCY-1:0][31:0] rdata_q, rdata_d;
  logic [2:0]               outstanding_q, outstanding_d;
  logic                     oob_q, oob_d;
  logic [15:0]              oob_count_q, oob_count_d;

  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic          rvalid;
  logic          gnt;
  logic          accept;

  // Address decode, grant and response visibility (all combinational).
  always_comb begin
    offset   = slave_req_i.addr - BASE_ADDR;
    in_range = offset < RANGE_BYTES;
    word_idx = offset[AW+1:2];
    rvalid   = valid_q[LATENCY-1] & ~rst_i;
    // A response slot frees up in the same cycle, so a full pipe can still grant.
    gnt      = slave_req_i.req & ~stall_i & ~rst_i &
               ((outstanding_q < MAX_OUT) | rvalid);
    accept   = slave_req_i.req & gnt;
  end

  // Next-state for the response pipeline, outstanding count and OOB tracking.
  always_comb begin
    valid_d       = '0;
    rdata_d       = '0;
    valid_d[0]    = accept;
    if (accept && !slave_req_i.we) begin
      rdata_d[0] = in_range ? mem_q[word_idx] : OOB_RDATA;
    end
    for (int i = 1; i < int'(LATENCY); i++) begin
      valid_d[i] = valid_q[i-1];
      rdata_d[i] = rdata_q[i-1];
    end
    outstanding_d = outstanding_q + {2'b00, accept} - {2'b00, rvalid};
    oob_d         = accept & ~in_range;
    oob_count_d   = oob_count_q;
    if (oob_d && (oob_count_q != 16'hFFFF)) begin
      oob_count_d = oob_count_q + 16'd1;
    end
  end

  // Control registers with synchronous reset; in-flight responses are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q       <= '0;
      rdata_q       <= '0;
      outstanding_q <= '0;
      oob_q         <= 1'b0;
      oob_count_q   <= '0;
    end else begin
      valid_q       <= valid_d;
      rdata_q       <= rdata_d;
      outstanding_q <= outstanding_d;
      oob_q         <= oob_d;
      oob_count_q   <= oob_count_d;
    end
  end

  // Byte-enabled write at the accept edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && slave_req_i.we && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (slave_req_i.be[b]) begin
          mem_q[word_idx][8*b +: 8] <= slave_req_i.wdata[8*b +: 8];
        end
      end
    end
  end

  // Outputs are forced to zero while reset is held, even before the first edge.
  always_comb begin
    slave_resp_o.gnt    = gnt;
    slave_resp_o.rvalid = rvalid;
    slave_resp_o.rdata  = rvalid ? rdata_q[LATENCY-1] : 32'h0;
    oob_o               = oob_q & ~rst_i;
    oob_count_o         = rst_i ? 16'h0 : oob_count_q;
    outstanding_o       = rst_i ? 3'h0 : outstanding_q;
  end

endmodule
